// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction loader: loader FSM states,
// word geometry and the word-count to byte-address helper.
package riscv_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  // Byte address of a word: zero-extended word count with two zero LSBs.
  function automatic logic [31:0] word_addr(input logic [15:0] cnt);
    return {14'b0, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
//
// Handshake: a byte transfers on a rising clk edge exactly when
// byte_valid_i and byte_ready_o are both 1 in the preceding cycle. The
// source must hold byte_i stable while byte_valid_i is high and not yet
// accepted; the loader may drop byte_ready_o at any time. mem_we_o is a
// single-cycle strobe per word with no back-pressure; mem_addr_o and
// mem_wdata_o are only meaningful while mem_we_o is 1.
interface instr_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;

  // Loader side.
  modport master (
    input  byte_i, byte_valid_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Byte source / memory side.
  modport slave (
    output byte_i, byte_valid_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word. Each pushed byte
// enters at the top and the word shifts down, so after four pushes the
// first byte sits in bits [7:0].
module byte_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [IDX_W-1:0] idx_d, idx_q;
  logic [31:0]      word_d, word_q;

  // Next byte index and shifted word; clear restarts at byte 0.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      idx_d  = idx_q + IDX_W'(1);
      word_d = {byte_i, word_q[31:8]};
    end
  end

  // Index and partial word registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = push_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_loader.sv
// Loads a program from a byte stream into instruction memory one word at
// a time and holds the core in reset until a complete load finishes.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [15:0]   len_i,
  instr_loader_if.master bus,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output loader_state_e state_o
);

  loader_state_e state_d, state_q;
  logic [15:0]   word_cnt_d, word_cnt_q;
  logic [15:0]   len_d, len_q;
  logic          ready_d, ready_q;
  logic          we_d, we_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          core_rst_d, core_rst_q;
  logic          err_d, err_q;

  logic          xfer;
  logic          clear;
  logic          word_done;
  logic          len_ok;
  logic [15:0]   word_cnt_inc;
  logic [31:0]   word;

  assign xfer         = (state_q == ST_LOAD) && ready_q && bus.byte_valid_i;
  assign len_ok       = $unsigned(32'(len_i)) <= $unsigned(32'(DEPTH_WORDS));
  assign word_cnt_inc = word_cnt_q + 16'd1;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .push_i     (xfer),
    .byte_i     (bus.byte_i),
    .word_o     (word),
    .word_done_o(word_done)
  );

  // Next state and next registered outputs of the loader FSM.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    ready_d    = ready_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    core_rst_d = core_rst_q;
    err_d      = err_q;
    clear      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          if (len_i == 16'd0) begin
            // Nothing to load: the (empty) program is immediately valid.
            state_d    = ST_DONE;
            word_cnt_d = '0;
            clear      = 1'b1;
            ready_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
            err_d      = 1'b0;
          end else if (len_ok) begin
            state_d    = ST_LOAD;
            word_cnt_d = '0;
            len_d      = len_i;
            clear      = 1'b1;
            ready_d    = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            core_rst_d = 1'b1;
            err_d      = 1'b0;
          end else begin
            // Rejected: state and loaded program are left untouched.
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (word_done) begin
          state_d = ST_WRITE;
          ready_d = 1'b0;
          we_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_inc;
        if (word_cnt_inc == len_q) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          core_rst_d = 1'b0;
        end else begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader FSM registers; reset wins over start and byte transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = word_addr(word_cnt_q);
  assign bus.mem_wdata_o  = word;
  assign core_rst_o       = core_rst_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus random
// loads compared against a word-assembly reference model.
module tb_instr_loader;
  import riscv_pkg::*;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [15:0]   len_i = '0;
  logic          core_rst_o, busy_o, done_o, err_o;
  loader_state_e state_o;

  instr_loader_if bus_if ();

  instr_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .len_i     (len_i),
    .bus       (bus_if),
    .core_rst_o(core_rst_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  logic [7:0]  tx_q[$];
  int          stall_q[$];
  bit          junk_start = 1'b0;

  // status = {byte_ready, mem_we, busy, done, err, core_rst}
  function automatic logic [5:0] status();
    return {bus_if.byte_ready_o, bus_if.mem_we_o, busy_o, done_o, err_o, core_rst_o};
  endfunction

  // Write monitor: capture every strobe; a write cycle never accepts bytes.
  always @(negedge clk) begin
    if (bus_if.mem_we_o === 1'b1) begin
      obs_addr_q.push_back(bus_if.mem_addr_o);
      obs_data_q.push_back(bus_if.mem_wdata_o);
      n_cmp++;
      if (bus_if.byte_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_write: got %b expected 0", bus_if.byte_ready_o);
      end
    end
  end

  // ---------------- driver tasks (all exit at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] len);
    start_i = 1'b1;
    len_i   = len;
    @(posedge clk); #1;
    start_i = 1'b0;
    len_i   = 16'($urandom);
  endtask

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
    tx_q.push_back(b3);
  endtask

  task automatic send_stream(input string tag);
    bit got;
    for (int i = 0; i < tx_q.size(); i++) begin
      int stall;
      stall = (i < stall_q.size()) ? stall_q[i] : 0;
      for (int s = 0; s < stall; s++) begin
        bus_if.byte_valid_i = 1'b0;
        bus_if.byte_i       = 8'($urandom);
        start_i             = junk_start;
        len_i               = 16'($urandom_range(0, 3));
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      bus_if.byte_valid_i = 1'b1;
      bus_if.byte_i       = tx_q[i];
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (bus_if.byte_ready_o === 1'b1) got = 1'b1;
        @(posedge clk); #1;
      end
      bus_if.byte_valid_i = 1'b0;
      n_cmp++;
      if (!got) begin
        n_fail++;
        $display("FAIL %s_byte_accept: byte %0d not accepted in 20 cycles, expected accept", tag, i);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (done_o === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done_o=%b after 50 cycles, expected 1", tag, done_o);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: word w is bytes 4w..4w+3 little-endian at address 4w.
  task automatic build_model();
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int w = 0; w < tx_q.size() / WORD_BYTES; w++) begin
      logic [31:0] data = '0;
      for (int k = 0; k < WORD_BYTES; k++)
        data = data + (32'(tx_q[WORD_BYTES * w + k]) << (8 * k));
      exp_addr_q.push_back(32'(w * 4));
      exp_data_q.push_back(data);
    end
  endtask

  task automatic check_writes(input string tag);
    n_cmp++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d writes expected %0d", tag, obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: got addr %h data %h expected addr %h data %h",
                 tag, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic clear_run();
    obs_addr_q.delete();
    obs_data_q.delete();
    tx_q.delete();
    stall_q.delete();
    junk_start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [5:0] exp_st, input loader_state_e exp_state);
    n_cmp++;
    if (status() !== exp_st || state_o !== exp_state) begin
      n_fail++;
      $display("FAIL %s: got status %b state %0d expected status %b state %0d",
               tag, status(), state_o, exp_st, exp_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; len_i = 16'd1;
    bus_if.byte_valid_i = 1'b1; bus_if.byte_i = 8'h55;
    @(posedge clk); #1;
    @(negedge clk);
    check_status("reset_state", 6'b000001, ST_IDLE);
    rst = 1'b0; start_i = 1'b0; bus_if.byte_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    do_reset();
    clear_run();
    push4(8'h13, 8'h00, 8'h00, 8'h00);
    push4(8'h93, 8'h00, 8'h10, 8'h00);
    do_start(16'd2);
    @(negedge clk);
    check_status("nominal_load_entry", 6'b101001, ST_LOAD);
    @(posedge clk); #1;
    send_stream("nominal");
    wait_done("nominal");
    exp_addr_q = {32'h0, 32'h4};
    exp_data_q = {32'h0000_0013, 32'h0010_0093};
    check_writes("nominal");
    @(negedge clk);
    check_status("nominal_done_state", 6'b000100, ST_DONE);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_run();
    push4(8'h13, 8'h00, 8'h00, 8'h00);
    push4(8'h93, 8'h00, 8'h10, 8'h00);
    stall_q = {0, 0, 3, 0, 0, 0, 0, 0};
    do_start(16'd2);
    send_stream("backpressure");
    wait_done("backpressure");
    exp_addr_q = {32'h0, 32'h4};
    exp_data_q = {32'h0000_0013, 32'h0010_0093};
    check_writes("backpressure");
  endtask

  task automatic test_overlength();
    int ready_seen = 0;
    do_reset();
    clear_run();
    do_start(16'(DEPTH + 1));
    @(negedge clk);
    check_status("overlength_err", 6'b000011, ST_IDLE);
    @(posedge clk); #1;
    bus_if.byte_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_if.byte_i = 8'($urandom);
      @(negedge clk);
      if (bus_if.byte_ready_o !== 1'b0) ready_seen++;
      @(posedge clk); #1;
    end
    bus_if.byte_valid_i = 1'b0;
    n_cmp++;
    if (ready_seen != 0 || obs_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL overlength_no_accept: got ready %0d cycles, %0d writes expected 0, 0",
               ready_seen, obs_addr_q.size());
    end
  endtask

  task automatic test_zero_length();
    int ready_seen = 0;
    do_reset();
    clear_run();
    do_start(16'd0);
    @(negedge clk);
    check_status("zero_len_done", 6'b000100, ST_DONE);
    @(posedge clk); #1;
    bus_if.byte_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_if.byte_i = 8'($urandom);
      @(negedge clk);
      if (bus_if.byte_ready_o !== 1'b0) ready_seen++;
      @(posedge clk); #1;
    end
    bus_if.byte_valid_i = 1'b0;
    n_cmp++;
    if (ready_seen != 0 || obs_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len_no_write: got ready %0d cycles, %0d writes expected 0, 0",
               ready_seen, obs_addr_q.size());
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    clear_run();
    tx_q = {8'h11, 8'h22};
    do_start(16'd1);
    send_stream("midword_pre");
    // Reset collides with start and a valid byte; reset must win.
    rst = 1'b1; start_i = 1'b1; len_i = 16'd5;
    bus_if.byte_valid_i = 1'b1; bus_if.byte_i = 8'h33;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0; bus_if.byte_valid_i = 1'b0;
    @(negedge clk);
    check_status("midword_after_rst", 6'b000001, ST_IDLE);
    @(posedge clk); #1;
    clear_run();
    push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    do_start(16'd1);
    send_stream("midword");
    wait_done("midword");
    exp_addr_q = {32'h0};
    exp_data_q = {32'hDDCC_BBAA};
    check_writes("midword");
  endtask

  task automatic test_reload();
    clear_run();
    do_start(16'd2000);
    @(negedge clk);
    check_status("reload_rejected", 6'b000110, ST_DONE);
    @(posedge clk); #1;
    do_start(16'd1);
    @(negedge clk);
    check_status("reload_accepted", 6'b101001, ST_LOAD);
    @(posedge clk); #1;
    for (int i = 0; i < WORD_BYTES; i++) tx_q.push_back(8'($urandom));
    send_stream("reload");
    wait_done("reload");
    build_model();
    check_writes("reload");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len;
      if (it % 3 == 0) do_reset();
      clear_run();
      junk_start = 1'b1;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len * WORD_BYTES; i++) begin
        tx_q.push_back(8'($urandom));
        stall_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end
      do_start(16'(len));
      send_stream("random");
      wait_done("random");
      build_model();
      check_writes($sformatf("random%0d", it));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_if.byte_valid_i = 1'b0;
    bus_if.byte_i       = '0;
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_overlength();
    test_zero_length();
    test_reset_midword();
    test_reload();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
